i2c_apb_cmd_sched: RTL and testbench

//  Shares one i2c_master_top APB slave port between NUM_REQ requesters using round-robin arbitration.

---
 rtl/i2c_apb_cmd_sched.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_apb_cmd_sched.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_apb_cmd_sched.sv
// i2c_apb_cmd_sched
//   Shares the APB slave port of one i2c_master_top between NUM_REQ requesters.
//   Requesters are served round-robin, one single-byte I2C transfer at a time.
//   Each accepted command becomes an APB register sequence:
//     SADDR write -> TXD write (I2C writes only) -> CMD write -> STAT polls
//     -> RXD read (I2C reads that were ACKed) -> one-cycle response.
//
// Ports
//   pclk_i, preset_i      clock, synchronous active-high reset
//   req_valid_i[k]        requester k has a command pending
//   req_saddr_i[7k+:7]    7-bit I2C slave address of requester k
//   req_rw_i[k]           1 = I2C read, 0 = I2C write
//   req_wdata_i[8k+:8]    write byte of requester k
//   req_ready_o           one-hot accept strobe (the command is latched that cycle)
//   rsp_valid_o           one-hot, one-cycle completion pulse to the owner
//   rsp_rdata_o           read byte (0 for writes, NACK or timeout)
//   rsp_nack_o            slave NACKed the transfer
//   rsp_timeout_o         status stayed busy for POLL_MAX reads
//   psel_o .. pwdata_o    APB master outputs towards i2c_master_top
//   prdata_i, pready_i    APB read data / ready from i2c_master_top
//
// Handshakes
//   Request side: a requester holds req_valid_i and its data stable until it
//   sees its req_ready_o bit high; the command is captured on that clock edge.
//   APB side: setup cycle (psel=1, penable=0), then access cycles (psel=1,
//   penable=1) until pready_i=1; the transfer completes on that edge.
module i2c_apb_cmd_sched #(
    parameter int         NUM_REQ   = 2,
    parameter logic [7:0] REG_SADDR = 8'h00,
    parameter logic [7:0] REG_TXD   = 8'h01,
    parameter logic [7:0] REG_CMD   = 8'h02,
    parameter logic [7:0] REG_STAT  = 8'h03,
    parameter logic [7:0] REG_RXD   = 8'h04,
    parameter int         POLL_MAX  = 255
) (
    input  logic                 pclk_i,
    input  logic                 preset_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [7*NUM_REQ-1:0] req_saddr_i,
    input  logic [NUM_REQ-1:0]   req_rw_i,
    input  logic [8*NUM_REQ-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_REQ-1:0]   rsp_valid_o,
    output logic [7:0]           rsp_rdata_o,
    output logic                 rsp_nack_o,
    output logic                 rsp_timeout_o,
    output logic                 psel_o,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [7:0]           paddr_o,
    output logic [7:0]           pwdata_o,
    input  logic [7:0]           prdata_i,
    input  logic                 pready_i
);

    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SADDR, S_TXD, S_CMD, S_POLL, S_RXD, S_RESP
    } state_t;

    state_t             state, nxt;
    logic [PTR_W-1:0]   rr_ptr, owner, win;
    logic               found;
    logic [7:0]         poll_cnt;
    logic [6:0]         cmd_saddr, sel_saddr;
    logic               cmd_rw, sel_rw;
    logic [7:0]         cmd_wdata, sel_wdata;
    logic [NUM_REQ-1:0] owner_oh;
    logic               busy, poll_expired;

    assign busy         = prdata_i[0];
    // poll_cnt counts busy reads already taken; this read is number poll_cnt+1
    assign poll_expired = (poll_cnt >= 8'(POLL_MAX - 1));

    // Round-robin search starting at rr_ptr, wrapping around.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = idx[PTR_W-1:0];
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        sel_saddr = '0;
        sel_rw    = 1'b0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == PTR_W'(k)) begin
                sel_saddr = req_saddr_i[7*k +: 7];
                sel_rw    = req_rw_i[k];
                sel_wdata = req_wdata_i[8*k +: 8];
            end
        end
    end

    // Ready is gated by reset: a grant shown during reset would never be latched.
    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
        req_ready_o     = '0;
        if (state == S_IDLE && found && !preset_i) req_ready_o[win] = 1'b1;
    end

    // Follow-on state once the current APB transfer completes.
    always_comb begin
        case (state)
            S_SADDR: nxt = cmd_rw ? S_CMD : S_TXD;
            S_TXD:   nxt = S_CMD;
            S_CMD:   nxt = S_POLL;
            S_POLL:  begin
                if (busy) nxt = poll_expired ? S_RESP : S_POLL;
                else      nxt = (cmd_rw && !prdata_i[1]) ? S_RXD : S_RESP;
            end
            S_RXD:   nxt = S_RESP;
            default: nxt = S_IDLE;
        endcase
    end

    // {pwrite, paddr, pwdata} for the setup phase of a transfer state.
    function automatic logic [16:0] setup_for(input state_t s);
        case (s)
            S_SADDR: setup_for = {1'b1, REG_SADDR, 1'b0, cmd_saddr};
            S_TXD:   setup_for = {1'b1, REG_TXD, cmd_wdata};
            S_CMD:   setup_for = {1'b1, REG_CMD, 6'b0, cmd_rw, 1'b1};
            S_POLL:  setup_for = {1'b0, REG_STAT, 8'h00};
            S_RXD:   setup_for = {1'b0, REG_RXD, 8'h00};
            default: setup_for = '0;
        endcase
    endfunction

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            poll_cnt      <= '0;
            cmd_saddr     <= '0;
            cmd_rw        <= 1'b0;
            cmd_wdata     <= '0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            pwrite_o      <= 1'b0;
            paddr_o       <= '0;
            pwdata_o      <= '0;
            rsp_valid_o   <= '0;
            rsp_rdata_o   <= '0;
            rsp_nack_o    <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        owner     <= win;
                        rr_ptr    <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                        cmd_saddr <= sel_saddr;
                        cmd_rw    <= sel_rw;
                        cmd_wdata <= sel_wdata;
                        poll_cnt  <= '0;
                        psel_o    <= 1'b1;
                        penable_o <= 1'b0;
                        // cmd_saddr is not loaded yet, so drive the SADDR setup directly
                        {pwrite_o, paddr_o, pwdata_o} <= {1'b1, REG_SADDR, 1'b0, sel_saddr};
                        state     <= S_SADDR;
                    end
                end
                S_RESP: begin
                    rsp_valid_o   <= '0;
                    rsp_rdata_o   <= '0;
                    rsp_nack_o    <= 1'b0;
                    rsp_timeout_o <= 1'b0;
                    state         <= S_IDLE;
                end
                default: begin
                    if (!penable_o) begin
                        penable_o <= 1'b1;
                    end else if (pready_i) begin
                        state <= nxt;
                        if (state == S_POLL && busy) poll_cnt <= poll_cnt + 8'd1;
                        if (nxt == S_RESP) begin
                            psel_o        <= 1'b0;
                            penable_o     <= 1'b0;
                            {pwrite_o, paddr_o, pwdata_o} <= '0;
                            rsp_valid_o   <= owner_oh;
                            rsp_rdata_o   <= (state == S_RXD) ? prdata_i : 8'h00;
                            rsp_nack_o    <= (state == S_POLL) && !busy && prdata_i[1];
                            rsp_timeout_o <= (state == S_POLL) && busy;
                        end else begin
                            // back-to-back: next setup phase starts right away
                            penable_o <= 1'b0;
                            {pwrite_o, paddr_o, pwdata_o} <= setup_for(nxt);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_apb_cmd_sched.sv
// Directed testbench for i2c_apb_cmd_sched (NUM_REQ=2, POLL_MAX=4).
// A small APB slave model with programmable wait states and a scripted
// status-register sequence logs every completed APB transfer as
// {pwrite, paddr, data}; each test compares that log and the responses
// against hand-written expected values.
module tb_i2c_apb_cmd_sched;

    logic        clk = 1'b0;
    logic        preset;
    logic [1:0]  req_valid;
    logic [13:0] req_saddr;
    logic [1:0]  req_rw;
    logic [15:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_nack;
    logic        rsp_timeout;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr, pwdata, prdata;
    logic        pready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // APB slave model configuration
    int         wait_states  = 0;
    int         wait_cnt     = 0;
    int         stat_rd_cnt  = 0;
    int         stat_off     = 0;
    int         stat_len     = 0;
    logic [7:0] stat_seq [4];
    logic [7:0] stat_default = 8'h00;
    logic [7:0] rxd_val      = 8'h00;

    // logs and scoreboard
    logic [16:0] apb_q[$];
    logic [16:0] exp_q[$];
    logic [11:0] rsp_q[$];
    int          rsp_cyc_q[$];
    int          gnt_cnt = 0;

    i2c_apb_cmd_sched #(
        .NUM_REQ (2),
        .POLL_MAX(4)
    ) dut (
        .pclk_i       (clk),
        .preset_i     (preset),
        .req_valid_i  (req_valid),
        .req_saddr_i  (req_saddr),
        .req_rw_i     (req_rw),
        .req_wdata_i  (req_wdata),
        .req_ready_o  (req_ready),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_nack_o   (rsp_nack),
        .rsp_timeout_o(rsp_timeout),
        .psel_o       (psel),
        .penable_o    (penable),
        .pwrite_o     (pwrite),
        .paddr_o      (paddr),
        .pwdata_o     (pwdata),
        .prdata_i     (prdata),
        .pready_i     (pready)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- APB slave model ----------------
    assign pready = psel && penable && (wait_cnt == wait_states);

    always_comb begin
        int sidx;
        sidx   = stat_rd_cnt - stat_off;
        prdata = 8'h00;
        if (paddr == 8'h03) prdata = (sidx < stat_len) ? stat_seq[sidx] : stat_default;
        else if (paddr == 8'h04) prdata = rxd_val;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (psel && penable && !pready) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
        if (psel && penable && pready) begin
            apb_q.push_back({pwrite, paddr, pwrite ? pwdata : prdata});
            if (!pwrite && paddr == 8'h03) stat_rd_cnt <= stat_rd_cnt + 1;
        end
    end

    // response / grant monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rsp_valid != 2'b00) begin
            rsp_q.push_back({rsp_valid, rsp_rdata, rsp_nack, rsp_timeout});
            rsp_cyc_q.push_back(cyc);
        end
        if (req_ready != 2'b00) gnt_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        apb_q.delete();
        exp_q.delete();
        rsp_q.delete();
        rsp_cyc_q.delete();
    endtask

    task automatic set_stat(input int len, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] dflt);
        stat_seq[0]  = s0;
        stat_seq[1]  = s1;
        stat_seq[2]  = s2;
        stat_seq[3]  = 8'h00;
        stat_len     = len;
        stat_default = dflt;
        stat_off     = stat_rd_cnt;
    endtask

    task automatic start_req(input int k, input logic [6:0] sa, input logic rw, input logic [7:0] wd);
        req_saddr[7*k +: 7] = sa;
        req_rw[k]           = rw;
        req_wdata[8*k +: 8] = wd;
        req_valid[k]        = 1'b1;
    endtask

    task automatic wait_grant(input int k, output int gcyc);
        bit got;
        got  = 1'b0;
        gcyc = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_ready[k]) begin
                got  = 1'b1;
                gcyc = cyc;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL grant_req%0d: ready not seen in 100 cycles, required a pulse", k);
        end
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int t;
        t = 0;
        while (rsp_q.size() < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (rsp_q.size() < n) begin
            errors++;
            $display("FAIL rsp_count: got %0d responses, required %0d", rsp_q.size(), n);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        preset    = 1'b1;
        req_valid = 2'b01;
        req_saddr = '0;
        req_rw    = '0;
        req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 00", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        preset    = 1'b0;
        @(negedge clk);
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata} !== 19'h0) begin
            errors++;
            $display("FAIL reset_apb: got psel=%b pen=%b pwr=%b addr=%h wdata=%h, required all 0",
                     psel, penable, pwrite, paddr, pwdata);
        end
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_nack, rsp_timeout} !== 12'h0) begin
            errors++;
            $display("FAIL reset_rsp: got valid=%b rdata=%h nack=%b to=%b, required all 0",
                     rsp_valid, rsp_rdata, rsp_nack, rsp_timeout);
        end
    endtask

    task automatic test_write();
        int          g;
        logic [11:0] r;
        clear_logs();
        wait_states = 0;
        set_stat(0, 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        start_req(0, 7'h50, 1'b0, 8'hA5);
        wait_grant(0, g);
        wait_rsp(1);
        exp_q = '{17'h10050, 17'h101A5, 17'h10201, 17'h00300};
        checks++;
        if (apb_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL write_apb_len: got %0d transfers, required %0d", apb_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= apb_q.size() || apb_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL write_apb[%0d]: got %h, required %h", i,
                         (i < apb_q.size()) ? apb_q[i] : 17'h1ffff, exp_q[i]);
            end
        end
        r = (rsp_q.size() > 0) ? rsp_q[0] : 12'hfff;
        checks++;
        if (r !== {2'b01, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL write_rsp: got %h, required %h", r, {2'b01, 8'h00, 1'b0, 1'b0});
        end
        checks++;
        if (rsp_cyc_q.size() == 0 || rsp_cyc_q[0] - g != 9) begin
            errors++;
            $display("FAIL write_latency: got %0d cycles grant-to-rsp, required 9",
                     (rsp_cyc_q.size() > 0) ? rsp_cyc_q[0] - g : -1);
        end
    endtask

    task automatic test_read_wait();
        int          g;
        logic [11:0] r;
        clear_logs();
        wait_states = 2;
        rxd_val     = 8'h5A;
        set_stat(0, 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        start_req(1, 7'h3C, 1'b1, 8'h00);
        wait_grant(1, g);
        wait_rsp(1);
        exp_q = '{17'h1003C, 17'h10203, 17'h00300, 17'h0045A};
        checks++;
        if (apb_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL read_apb_len: got %0d transfers, required %0d", apb_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= apb_q.size() || apb_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL read_apb[%0d]: got %h, required %h", i,
                         (i < apb_q.size()) ? apb_q[i] : 17'h1ffff, exp_q[i]);
            end
        end
        r = (rsp_q.size() > 0) ? rsp_q[0] : 12'hfff;
        checks++;
        if (r !== {2'b10, 8'h5A, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL read_rsp: got %h, required %h", r, {2'b10, 8'h5A, 1'b0, 1'b0});
        end
        // 1 grant + 4 transfers x (setup + 3 access) = 17 cycles to RESP
        checks++;
        if (rsp_cyc_q.size() == 0 || rsp_cyc_q[0] - g != 17) begin
            errors++;
            $display("FAIL read_latency: got %0d cycles grant-to-rsp, required 17",
                     (rsp_cyc_q.size() > 0) ? rsp_cyc_q[0] - g : -1);
        end
        wait_states = 0;
    endtask

    task automatic test_arbitration();
        logic [1:0] order [4];
        logic [1:0] exp_o [4];
        int         n, g0;
        clear_logs();
        set_stat(0, 8'h00, 8'h00, 8'h00, 8'h00);
        exp_o = '{2'b01, 2'b10, 2'b01, 2'b10};
        n     = 0;
        g0    = gnt_cnt;
        @(posedge clk);
        #1;
        start_req(0, 7'h10, 1'b0, 8'h11);
        start_req(1, 7'h20, 1'b0, 8'h22);
        for (int t = 0; t < 200 && n < 4; t++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                order[n] = req_ready;
                n++;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_rsp(4);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL arb_grants: got %0d grants, required 4", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (order[i] !== exp_o[i]) begin
                errors++;
                $display("FAIL arb_order[%0d]: got %b, required %b", i, order[i], exp_o[i]);
            end
        end
        checks++;
        if (gnt_cnt - g0 != 4) begin
            errors++;
            $display("FAIL arb_pulses: got %0d ready pulses, required 4", gnt_cnt - g0);
        end
        // first APB write of each command carries the granted requester's address
        exp_q = '{17'h10010, 17'h10020, 17'h10010, 17'h10020};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (4*i >= apb_q.size() || apb_q[4*i] !== exp_q[i]) begin
                errors++;
                $display("FAIL arb_saddr[%0d]: got %h, required %h", i,
                         (4*i < apb_q.size()) ? apb_q[4*i] : 17'h1ffff, exp_q[i]);
            end
            checks++;
            if (i >= rsp_q.size() || rsp_q[i][11:10] !== exp_o[i]) begin
                errors++;
                $display("FAIL arb_rsp_owner[%0d]: got %b, required %b", i,
                         (i < rsp_q.size()) ? rsp_q[i][11:10] : 2'b11, exp_o[i]);
            end
        end
    endtask

    task automatic test_nack();
        int          g;
        logic [11:0] r;
        clear_logs();
        rxd_val = 8'h5A;
        set_stat(3, 8'h01, 8'h01, 8'h02, 8'h00);
        @(posedge clk);
        #1;
        start_req(0, 7'h21, 1'b1, 8'h00);
        wait_grant(0, g);
        wait_rsp(1);
        exp_q = '{17'h10021, 17'h10203, 17'h00301, 17'h00301, 17'h00302};
        checks++;
        if (apb_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL nack_apb_len: got %0d transfers, required %0d", apb_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= apb_q.size() || apb_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL nack_apb[%0d]: got %h, required %h", i,
                         (i < apb_q.size()) ? apb_q[i] : 17'h1ffff, exp_q[i]);
            end
        end
        r = (rsp_q.size() > 0) ? rsp_q[0] : 12'hfff;
        checks++;
        if (r !== {2'b01, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL nack_rsp: got %h, required %h", r, {2'b01, 8'h00, 1'b1, 1'b0});
        end
    endtask

    task automatic test_timeout();
        int          g;
        logic [11:0] r;
        clear_logs();
        set_stat(0, 8'h00, 8'h00, 8'h00, 8'h01);
        @(posedge clk);
        #1;
        start_req(1, 7'h11, 1'b0, 8'h99);
        wait_grant(1, g);
        wait_rsp(1);
        exp_q = '{17'h10011, 17'h10199, 17'h10201,
                  17'h00301, 17'h00301, 17'h00301, 17'h00301};
        checks++;
        if (apb_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL timeout_apb_len: got %0d transfers, required %0d", apb_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= apb_q.size() || apb_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL timeout_apb[%0d]: got %h, required %h", i,
                         (i < apb_q.size()) ? apb_q[i] : 17'h1ffff, exp_q[i]);
            end
        end
        r = (rsp_q.size() > 0) ? rsp_q[0] : 12'hfff;
        checks++;
        if (r !== {2'b10, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL timeout_rsp: got %h, required %h", r, {2'b10, 8'h00, 1'b0, 1'b1});
        end
    endtask

    task automatic test_reset_in_poll();
        int         g;
        bit         in_poll;
        logic [1:0] first;
        clear_logs();
        set_stat(0, 8'h00, 8'h00, 8'h00, 8'h01);
        @(posedge clk);
        #1;
        start_req(0, 7'h33, 1'b0, 8'h44);
        wait_grant(0, g);
        in_poll = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (psel && paddr == 8'h03) begin
                in_poll = 1'b1;
                break;
            end
        end
        checks++;
        if (!in_poll) begin
            errors++;
            $display("FAIL rip_reach_poll: status read not seen, required within 50 cycles");
        end
        @(posedge clk);
        #1;
        preset = 1'b1;
        @(posedge clk);
        #1;
        preset = 1'b0;
        checks++;
        if ({psel, penable, pwrite, paddr, pwdata} !== 19'h0) begin
            errors++;
            $display("FAIL rip_apb_clear: got psel=%b pen=%b pwr=%b addr=%h wdata=%h, required all 0",
                     psel, penable, pwrite, paddr, pwdata);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (rsp_q.size() != 0) begin
            errors++;
            $display("FAIL rip_no_rsp: got %0d responses, required 0", rsp_q.size());
        end
        set_stat(0, 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        start_req(0, 7'h01, 1'b0, 8'h02);
        start_req(1, 7'h03, 1'b0, 8'h04);
        first = 2'b00;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                first = req_ready;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        checks++;
        if (first !== 2'b01) begin
            errors++;
            $display("FAIL rip_first_grant: got %b, required 01", first);
        end
        wait_rsp(1);
        checks++;
        if (rsp_q.size() == 0 || rsp_q[0] !== {2'b01, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rip_rsp: got %h, required %h",
                     (rsp_q.size() > 0) ? rsp_q[0] : 12'hfff, {2'b01, 8'h00, 1'b0, 1'b0});
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_arbitration();
        test_nack();
        test_timeout();
        test_reset_in_poll();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
